// File: rtl/compare_window_bank_pkg.sv
// compare_window_bank_pkg: shared limits and priority-encoder helper for the comparator bank
package compare_window_bank_pkg;
  localparam int CHANNELS_MAX = 8;
  function automatic int unsigned lowest_set(input logic [CHANNELS_MAX-1:0] v);
    int unsigned idx = 0;
    for (int i = CHANNELS_MAX - 1; i >= 0; i--) if (v[i]) idx = unsigned'(i);
    return idx;
  endfunction
endpackage

// File: rtl/compare_window_bank_channel.sv
// compare_window_bank_channel: one runtime-programmable masked equality comparator
module compare_window_bank_channel #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_wr,
  input  logic             cfg_enable,
  input  logic [WIDTH-1:0] cfg_value,
  input  logic [WIDTH-1:0] cfg_mask,
  input  logic [WIDTH-1:0] value,
  output logic             hit
);
  logic             enable_q, enable_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  // load new config on a write strobe, otherwise hold
  always_comb begin
    enable_d = cfg_wr ? cfg_enable : enable_q;
    value_d  = cfg_wr ? cfg_value : value_q;
    mask_d   = cfg_wr ? cfg_mask : mask_q;
  end
  // config registers; a compare on the write edge still sees the old config
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_q <= 1'b0;
      value_q  <= '0;
      mask_q   <= '0;
    end else begin
      enable_q <= enable_d;
      value_q  <= value_d;
      mask_q   <= mask_d;
    end
  end
  assign hit = enable_q && (((value ^ value_q) & mask_q) == '0);
endmodule

// File: rtl/compare_window_bank.sv
// compare_window_bank: bank of masked comparators with registered hit vector, priority index and sticky flags
module compare_window_bank
  import compare_window_bank_pkg::*;
#(
  parameter int WIDTH    = 9,
  parameter int CHANNELS = 4,
  parameter int INDEX_W  = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfgWrite,
  input  logic [INDEX_W-1:0]  cfgChannel,
  input  logic                cfgEnable,
  input  logic [WIDTH-1:0]    cfgValue,
  input  logic [WIDTH-1:0]    cfgMask,
  input  logic                inValid,
  input  logic [WIDTH-1:0]    value,
  input  logic                clearHits,
  output logic                outValid,
  output logic [CHANNELS-1:0] matchVector,
  output logic                matchAny,
  output logic [INDEX_W-1:0]  matchIndex,
  output logic [CHANNELS-1:0] hitFlags
);
  logic [CHANNELS-1:0]     hit_vec;
  logic [CHANNELS_MAX-1:0] hit_pad;
  logic                    out_valid_q, out_valid_d;
  logic [CHANNELS-1:0]     match_vector_q, match_vector_d;
  logic                    match_any_q, match_any_d;
  logic [INDEX_W-1:0]      match_index_q, match_index_d;
  logic [CHANNELS-1:0]     hit_flags_q, hit_flags_d;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    compare_window_bank_channel #(.WIDTH(WIDTH)) u_ch (
      .clk       (clk),
      .reset     (reset),
      .cfg_wr    (cfgWrite && cfgChannel == INDEX_W'(g)),
      .cfg_enable(cfgEnable),
      .cfg_value (cfgValue),
      .cfg_mask  (cfgMask),
      .value     (value),
      .hit       (hit_vec[g])
    );
  end

  // next result: zeroed when the input is not valid; flags set wins over clear
  always_comb begin
    hit_pad = '0;
    hit_pad[CHANNELS-1:0] = hit_vec;
    out_valid_d    = inValid;
    match_vector_d = inValid ? hit_vec : '0;
    match_any_d    = |match_vector_d;
    match_index_d  = inValid ? INDEX_W'(lowest_set(hit_pad)) : '0;
    hit_flags_d    = (clearHits ? '0 : hit_flags_q) | (out_valid_q ? match_vector_q : '0);
  end

  // result pipeline and sticky flags, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q    <= 1'b0;
      match_vector_q <= '0;
      match_any_q    <= 1'b0;
      match_index_q  <= '0;
      hit_flags_q    <= '0;
    end else begin
      out_valid_q    <= out_valid_d;
      match_vector_q <= match_vector_d;
      match_any_q    <= match_any_d;
      match_index_q  <= match_index_d;
      hit_flags_q    <= hit_flags_d;
    end
  end

  assign outValid    = out_valid_q;
  assign matchVector = match_vector_q;
  assign matchAny    = match_any_q;
  assign matchIndex  = match_index_q;
  assign hitFlags    = hit_flags_q;
endmodule

// File: tb/tb_compare_window_bank.sv
// tb_compare_window_bank: directed self-checking bench for compare_window_bank
module tb_compare_window_bank;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cfgWrite = 1'b0;
  logic [2:0] cfgChannel = '0;
  logic       cfgEnable = 1'b0;
  logic [8:0] cfgValue = '0;
  logic [8:0] cfgMask = '0;
  logic       inValid = 1'b0;
  logic [8:0] value = '0;
  logic       clearHits = 1'b0;
  logic       outValid;
  logic [3:0] matchVector;
  logic       matchAny;
  logic [2:0] matchIndex;
  logic [3:0] hitFlags;
  int tests = 0;
  int fails = 0;

  compare_window_bank #(.WIDTH(9), .CHANNELS(4), .INDEX_W(3)) dut (
    .clk(clk), .reset(reset), .cfgWrite(cfgWrite), .cfgChannel(cfgChannel),
    .cfgEnable(cfgEnable), .cfgValue(cfgValue), .cfgMask(cfgMask),
    .inValid(inValid), .value(value), .clearHits(clearHits),
    .outValid(outValid), .matchVector(matchVector), .matchAny(matchAny),
    .matchIndex(matchIndex), .hitFlags(hitFlags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [2:0] ch, input logic en, input logic [8:0] val, input logic [8:0] msk);
    cfgWrite = 1'b1;
    cfgChannel = ch;
    cfgEnable = en;
    cfgValue = val;
    cfgMask = msk;
  endtask

  task automatic res(input string tag, input logic ov, input logic [3:0] mv, input logic any, input logic [2:0] idx);
    chk({tag, "_ov"}, 16'(outValid), 16'(ov));
    chk({tag, "_mv"}, 16'(matchVector), 16'(mv));
    chk({tag, "_any"}, 16'(matchAny), 16'(any));
    chk({tag, "_idx"}, 16'(matchIndex), 16'(idx));
  endtask

  initial begin
    inValid = 1'b1;
    value = 9'h1A5;
    tick();
    tick();
    res("reset", 1'b0, 4'b0000, 1'b0, 3'd0);
    chk("reset_flags", 16'(hitFlags), 16'h0);
    inValid = 1'b0;
    reset = 1'b0;
    cfg(3'd0, 1'b1, 9'h1A5, 9'h1FF);
    tick();
    cfgWrite = 1'b0;
    inValid = 1'b1;
    value = 9'h1A5;
    tick();
    res("exact_hit", 1'b1, 4'b0001, 1'b1, 3'd0);
    value = 9'h1A4;
    tick();
    res("exact_miss", 1'b1, 4'b0000, 1'b0, 3'd0);
    chk("flag_after_hit", 16'(hitFlags), 16'h1);
    inValid = 1'b0;
    clearHits = 1'b1;
    tick();
    clearHits = 1'b0;
    res("idle_zeroed", 1'b0, 4'b0000, 1'b0, 3'd0);
    chk("flag_clear", 16'(hitFlags), 16'h0);
    cfg(3'd1, 1'b1, 9'h100, 9'h100);
    tick();
    cfg(3'd3, 1'b1, 9'h000, 9'h000);
    tick();
    cfgWrite = 1'b0;
    inValid = 1'b1;
    value = 9'h1FF;
    tick();
    res("prio", 1'b1, 4'b1010, 1'b1, 3'd1);
    inValid = 1'b0;
    cfg(3'd1, 1'b0, 9'h100, 9'h100);
    tick();
    cfgWrite = 1'b0;
    inValid = 1'b1;
    tick();
    res("prio_dis", 1'b1, 4'b1000, 1'b1, 3'd3);
    cfg(3'd2, 1'b1, 9'h055, 9'h1FF);
    value = 9'h055;
    tick();
    cfgWrite = 1'b0;
    res("race_old", 1'b1, 4'b1000, 1'b1, 3'd3);
    tick();
    res("race_new", 1'b1, 4'b1100, 1'b1, 3'd2);
    inValid = 1'b0;
    cfg(3'd5, 1'b1, 9'h000, 9'h000);
    tick();
    cfgWrite = 1'b0;
    res("oob_idle", 1'b0, 4'b0000, 1'b0, 3'd0);
    inValid = 1'b1;
    tick();
    res("oob_nochange", 1'b1, 4'b1100, 1'b1, 3'd2);
    inValid = 1'b0;
    cfg(3'd3, 1'b0, 9'h000, 9'h000);
    tick();
    cfgWrite = 1'b0;
    clearHits = 1'b1;
    tick();
    clearHits = 1'b0;
    chk("sticky_cleared", 16'(hitFlags), 16'h0);
    inValid = 1'b1;
    value = 9'h1A5;
    tick();
    res("sticky_res", 1'b1, 4'b0001, 1'b1, 3'd0);
    chk("sticky_trail", 16'(hitFlags), 16'h0);
    tick();
    chk("sticky_set", 16'(hitFlags), 16'h1);
    inValid = 1'b0;
    clearHits = 1'b1;
    tick();
    chk("sticky_set_wins", 16'(hitFlags), 16'h1);
    tick();
    clearHits = 1'b0;
    chk("sticky_clear", 16'(hitFlags), 16'h0);
    inValid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      value = (i % 2 == 0) ? 9'h1A5 : 9'h000;
      tick();
      chk($sformatf("b2b_ov%0d", i), 16'(outValid), 16'h1);
      chk($sformatf("b2b_any%0d", i), 16'(matchAny), (i % 2 == 0) ? 16'h1 : 16'h0);
    end
    value = 9'h1A5;
    tick();
    #2;
    reset = 1'b1;
    #1;
    res("async_rst", 1'b0, 4'b0000, 1'b0, 3'd0);
    chk("async_rst_flags", 16'(hitFlags), 16'h0);
    tick();
    chk("rst_hold_ov", 16'(outValid), 16'h0);
    reset = 1'b0;
    tick();
    res("cfg_cleared", 1'b1, 4'b0000, 1'b0, 3'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
